// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC, fetches over a
// request/ready memory port, and handles decode freeze, EXE redirect and slow-memory bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction,
  output logic        valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  // The request is gated by rst directly so nothing is fetched while reset is held.
  assign imem_req  = (state == S_REQ) && !rst;
  assign imem_addr = pc;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, exactly like the hardware flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= S_REQ;
      PC_out      <= '0;
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
      hold_pc     <= '0;
      hold_instr  <= '0;
    end else if (branch_taken) begin
      // Redirect wins over freeze; any word arriving this cycle or parked is dropped.
      pc          <= branch_addr;
      state       <= S_REQ;
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready && !freeze) begin
            PC_out      <= pc + STEP;
            instruction <= imem_rdata;
            valid       <= 1'b1;
            pc          <= pc + STEP;
          end else if (imem_ready) begin
            // Decode is frozen: park the word so the memory access is not lost.
            hold_instr <= imem_rdata;
            hold_pc    <= pc;
            state      <= S_HOLD;
          end else if (!freeze) begin
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            PC_out      <= hold_pc + STEP;
            instruction <= hold_instr;
            valid       <= 1'b1;
            pc          <= hold_pc + STEP;
            state       <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
